// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default parameters for the PC sequencer
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_INC
  } pc_sel_t;

  localparam int unsigned DEF_WORD_SIZE = 32;
  localparam int unsigned DEF_RESET_VEC = 0;
  localparam int unsigned DEF_INC       = 1;
  localparam int unsigned DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - request and status bundle between fetch control and the PC sequencer
interface pc_seq_if
  import pc_pkg::*;
#(
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE
);

  logic                 stall;
  logic                 jump_en;
  logic [WORD_SIZE-1:0] jump_addr;
  logic                 branch_en;
  logic [WORD_SIZE-1:0] branch_off;
  logic                 call_en;
  logic                 ret_en;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] pc_next;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 ras_ovf;
  logic                 ret_unf;

  modport master (
    output stall, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en,
    input  pc, pc_next, ras_empty, ras_full, ras_ovf, ret_unf
  );

  modport slave (
    input  stall, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en,
    output pc, pc_next, ras_empty, ras_full, ras_ovf, ret_unf
  );

endinterface

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WORD_SIZE,
  parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic             ovf_q;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign ovf   = ovf_q;
  // ptr is the next write slot, so once full it also points at the oldest entry
  assign top   = mem[ptr - PW'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (full) begin
        ovf_q <= 1'b1;
      end else begin
        count <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[ptr] <= push_data;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - registered program counter with priority decode of stall/ret/call/jump/branch/increment
module pc_seq
  import pc_pkg::*;
#(
  parameter int unsigned          WORD_SIZE = DEF_WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_VEC = WORD_SIZE'(DEF_RESET_VEC),
  parameter logic [WORD_SIZE-1:0] INC       = WORD_SIZE'(DEF_INC),
  parameter int unsigned          RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic     clk,
  input logic     rst_n,
  pc_seq_if.slave bus
);

  pc_sel_t              sel;
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] pc_n;
  logic [WORD_SIZE-1:0] ras_top;
  logic                 ras_empty;
  logic                 ras_full;
  logic                 ras_ovf;
  logic                 ras_push;
  logic                 ras_pop;

  always_comb begin
    sel = SEL_INC;
    if (bus.stall)          sel = SEL_HOLD;
    else if (bus.ret_en)    sel = SEL_RET;
    else if (bus.call_en)   sel = SEL_CALL;
    else if (bus.jump_en)   sel = SEL_JUMP;
    else if (bus.branch_en) sel = SEL_BRANCH;
  end

  assign pc_inc = pc_q + INC;

  // An empty-stack return degrades to a plain increment
  always_comb begin
    pc_n = pc_inc;
    case (sel)
      SEL_HOLD:   pc_n = pc_q;
      SEL_RET:    pc_n = ras_empty ? pc_inc : ras_top;
      SEL_CALL:   pc_n = bus.jump_addr;
      SEL_JUMP:   pc_n = bus.jump_addr;
      SEL_BRANCH: pc_n = pc_q + bus.branch_off;
      default:    pc_n = pc_inc;
    endcase
  end

  assign ras_push = (sel == SEL_CALL);
  assign ras_pop  = (sel == SEL_RET) && !ras_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_n;
    end
  end

  pc_ras #(
    .WIDTH (WORD_SIZE),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .ovf       (ras_ovf)
  );

  assign bus.pc        = pc_q;
  assign bus.pc_next   = pc_n;
  assign bus.ras_empty = ras_empty;
  assign bus.ras_full  = ras_full;
  assign bus.ras_ovf   = ras_ovf;
  assign bus.ret_unf   = (sel == SEL_RET) && ras_empty;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - directed bench for pc_seq with a queue-based reference model
module tb_pc_seq;

  localparam int          W    = 32;
  localparam logic [31:0] RV   = 32'h100;
  localparam logic [31:0] INCV = 32'h1;
  localparam int          D    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pc_seq_if #(.WORD_SIZE(W)) bus ();

  pc_seq #(
    .WORD_SIZE (W),
    .RESET_VEC (RV),
    .INC       (INCV),
    .RAS_DEPTH (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: stack is a plain queue, oldest at the front
  always @(negedge clk) begin
    logic [31:0] e_next;
    logic        e_unf;
    logic [31:0] old_pc;
    if (!rst_n) begin
      m_pc  = RV;
      m_ras.delete();
      m_ovf = 1'b0;
      chk("m_rst_pc", bus.pc, RV);
      chk("m_rst_next", bus.pc_next, RV + INCV);
      chk("m_rst_empty", {31'd0, bus.ras_empty}, 32'd1);
      chk("m_rst_full", {31'd0, bus.ras_full}, 32'd0);
      chk("m_rst_ovf", {31'd0, bus.ras_ovf}, 32'd0);
      chk("m_rst_unf", {31'd0, bus.ret_unf}, 32'd0);
    end else begin
      e_unf = 1'b0;
      if (bus.stall) e_next = m_pc;
      else if (bus.ret_en) begin
        if (m_ras.size() > 0) e_next = m_ras[$];
        else begin
          e_next = m_pc + INCV;
          e_unf  = 1'b1;
        end
      end
      else if (bus.call_en)   e_next = bus.jump_addr;
      else if (bus.jump_en)   e_next = bus.jump_addr;
      else if (bus.branch_en) e_next = m_pc + bus.branch_off;
      else                    e_next = m_pc + INCV;

      chk("m_pc", bus.pc, m_pc);
      chk("m_pc_next", bus.pc_next, e_next);
      chk("m_empty", {31'd0, bus.ras_empty}, {31'd0, m_ras.size() == 0});
      chk("m_full", {31'd0, bus.ras_full}, {31'd0, m_ras.size() == D});
      chk("m_ovf", {31'd0, bus.ras_ovf}, {31'd0, m_ovf});
      chk("m_unf", {31'd0, bus.ret_unf}, {31'd0, e_unf});

      old_pc = m_pc;
      m_pc   = e_next;
      if (!bus.stall) begin
        if (bus.ret_en) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end else if (bus.call_en) begin
          if (m_ras.size() == D) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(old_pc + INCV);
        end
      end
    end
  end

  task automatic set_in(input logic s, input logic j, input logic [31:0] ja, input logic b,
                        input logic [31:0] bo, input logic c, input logic r);
    bus.stall      = s;
    bus.jump_en    = j;
    bus.jump_addr  = ja;
    bus.branch_en  = b;
    bus.branch_off = bo;
    bus.call_en    = c;
    bus.ret_en     = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic s, input logic j, input logic [31:0] ja, input logic b,
                    input logic [31:0] bo, input logic c, input logic r);
    set_in(s, j, ja, b, bo, c, r);
    step();
  endtask

  task automatic idle();  op(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(input logic [31:0] a);  op(0, 1, a, 0, 0, 0, 0); endtask
  task automatic call(input logic [31:0] a); op(0, 0, a, 0, 0, 1, 0); endtask
  task automatic ret();   op(0, 0, 0, 0, 0, 0, 1); endtask

  logic [31:0] ret_exp [4];

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_pc", bus.pc, 32'h100);
    chk("rst_next", bus.pc_next, 32'h101);
    chk("rst_empty", {31'd0, bus.ras_empty}, 32'd1);

    idle(); chk("free1", bus.pc, 32'h101);
    idle(); chk("free2", bus.pc, 32'h102);
    chk("free_empty", {31'd0, bus.ras_empty}, 32'd1);

    jmp(32'h10);         chk("jump", bus.pc, 32'h10);
    op(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("branch_neg", bus.pc, 32'h0C);
    jmp(32'hFFFF_FFFF);
    idle();              chk("wrap", bus.pc, 32'h0);

    jmp(32'h40);
    call(32'h200);       chk("call_pc", bus.pc, 32'h200);
    chk("call_nonempty", {31'd0, bus.ras_empty}, 32'd0);
    ret();               chk("ret_pc", bus.pc, 32'h41);
    chk("ret_empty", {31'd0, bus.ras_empty}, 32'd1);

    call(32'h1000);
    call(32'h2000);
    call(32'h3000);
    call(32'h4000);
    chk("full4", {31'd0, bus.ras_full}, 32'd1);
    chk("no_ovf_yet", {31'd0, bus.ras_ovf}, 32'd0);
    call(32'h5000);
    chk("ovf_set", {31'd0, bus.ras_ovf}, 32'd1);
    chk("still_full", {31'd0, bus.ras_full}, 32'd1);
    ret_exp[0] = 32'h4001;
    ret_exp[1] = 32'h3001;
    ret_exp[2] = 32'h2001;
    ret_exp[3] = 32'h1001;
    for (int i = 0; i < 4; i++) begin
      ret();
      chk($sformatf("lifo%0d", i), bus.pc, ret_exp[i]);
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("unf_pulse", {31'd0, bus.ret_unf}, 32'd1);
    chk("unf_next", bus.pc_next, 32'h1002);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("unf_pc", bus.pc, 32'h1002);
    chk("unf_clear", {31'd0, bus.ret_unf}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      op(1, 1, 32'h500, 0, 0, 0, 0);
      chk("stall_hold", bus.pc, 32'h1002);
    end
    jmp(32'h500);        chk("stall_release_jump", bus.pc, 32'h500);
    for (int i = 0; i < 3; i++) op(1, 1, 32'h600, 0, 0, 0, 0);
    idle();              chk("stall_dropped", bus.pc, 32'h501);

    jmp(32'h54);
    call(32'h700);       chk("pre_both", bus.pc, 32'h700);
    op(0, 0, 32'h900, 0, 0, 1, 1);
    chk("both_pc", bus.pc, 32'h55);
    chk("both_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("ovf_sticky", {31'd0, bus.ras_ovf}, 32'd1);
    call(32'h800);
    chk("pre_rst_nonempty", {31'd0, bus.ras_empty}, 32'd0);

    set_in(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("async_pc", bus.pc, RV);
    chk("async_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("async_ovf", {31'd0, bus.ras_ovf}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    chk("post_rst_pc", bus.pc, 32'h100);
    idle();              chk("post_rst_inc", bus.pc, 32'h101);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the MIPS core fetch stage. It holds the current instruction address and advances it every clock by a fixed increment, a signed relative branch, an absolute jump, or a subroutine call/return. A small circular return-address stack (RAS) supports the call/return path. It replaces the level-triggered counter with a single-clock, registered design that has explicit stall and priority rules.

## Interface
- `WORD_SIZE`, 32: address width in bits.
- `RESET_VEC`, 0: value loaded into `pc` on reset.
- `INC`, 1: sequential increment (word-addressed).
- `RAS_DEPTH`, 4: return-stack entries, power of two, ≥ 2.

Ports:
- `clk` in 1: the single clock; rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold `pc` and RAS unchanged.
- `jump_en` in 1: absolute jump to `jump_addr`.
- `jump_addr` in WORD_SIZE: jump/call target.
- `branch_en` in 1: relative branch.
- `branch_off` in WORD_SIZE: signed two's-complement offset.
- `call_en` in 1: call; target is `jump_addr`, pushes return address.
- `ret_en` in 1: return; pops RAS top into `pc`.
- `pc` out WORD_SIZE: registered current address.
- `pc_next` out WORD_SIZE: combinational value `pc` takes at next edge.
- `ras_empty` out 1: RAS holds no entries.
- `ras_full` out 1: RAS holds RAS_DEPTH entries.
- `ras_ovf` out 1: sticky, set when a call overwrote an entry.
- `ret_unf` out 1: one-cycle pulse, return attempted on empty RAS.

## Operation
- Per-cycle priority: `stall` > `ret_en` > `call_en` > `jump_en` > `branch_en` > increment.
- `stall`: `pc`, RAS, and `ras_ovf` hold. `ret_unf` = 0. All other requests are ignored, not queued.
- increment: `pc_next = pc + INC`.
- branch: `pc_next = pc + branch_off`.
- jump: `pc_next = jump_addr`.
- call: `pc_next = jump_addr`. Push `pc + INC`.
- return, RAS non-empty: `pc_next = top`. Pop.
- return, RAS empty: `pc_next = pc + INC`. `ret_unf` = 1 for that cycle.
- Call with RAS full: overwrite the oldest entry (circular). Count stays RAS_DEPTH. Set `ras_ovf`; it clears only on reset.
- `call_en` and `ret_en` together: return executes, call is dropped (no push).
- All arithmetic is modulo 2^WORD_SIZE. Wrap-around is silent, with no flag.
- RAS count ranges 0..RAS_DEPTH. `ras_empty = (count==0)`, `ras_full = (count==RAS_DEPTH)`.

## Timing
- Reset (async assert, synchronous-safe deassert by the caller): `pc`=RESET_VEC, count=0, `ras_empty`=1, `ras_full`=0, `ras_ovf`=0, `ret_unf`=0. `pc_next` then evaluates to RESET_VEC+INC.
- Reset asserted mid-operation discards the RAS contents immediately and forces the reset state at once, with no clock needed.
- Requests are sampled at the rising edge. The new `pc` is visible one cycle later (latency 1).
- `pc_next` reflects the current-cycle inputs combinationally; it has no register.
- `ret_unf` is asserted in the cycle the empty return is sampled. It is combinational from `ret_en`, `stall`, and count.
- Back-to-back calls and returns at full rate are supported. A return in the cycle right after a call pops the just-pushed value.

## Structure
- Package `pc_pkg`: `pc_sel_t` enum {SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_INC} and a default-parameter constants block.
- Sub-module `pc_ras`: circular LIFO with push, pop, top, count, empty, full, and ovf. Top-level `pc_seq` holds the priority decode, adders, and `pc` register.

## Test plan
- Reset then 3 free-running cycles, RESET_VEC=0x100, INC=1 -> `pc` = 0x100, 0x101, 0x102; `ras_empty`=1.
- `pc`=0x10, `branch_off`=0xFFFFFFFC -> next `pc`=0x0C. `pc`=0xFFFFFFFF, increment -> `pc`=0x0.
- Call to 0x200 from `pc`=0x40, then ret -> `pc` = 0x200, then 0x41; `ras_empty` back to 1.
- Five nested calls with RAS_DEPTH=4, then five rets -> first four rets return in LIFO order. `ras_ovf`=1. The fifth ret pulses `ret_unf` and increments `pc`.
- `stall` held 3 cycles with `jump_en` high -> `pc` unchanged. After release, the jump takes effect only if `jump_en` is still high.
- `call_en`+`ret_en` together with RAS holding 0x55 -> `pc`=0x55, count decrements, no push. Then `rst_n` low mid-sequence -> `pc`=RESET_VEC immediately and RAS empty.
